// File: rtl/mem_port_arbiter_if.sv
// Requester, response and memory-side signals of the two-port memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic            s0_valid;
    logic            s1_valid;
    logic            s0_ready;
    logic            s1_ready;
    logic [AW-1:0]   s0_addr;
    logic [AW-1:0]   s1_addr;
    logic            s0_we;
    logic            s1_we;
    logic [DW-1:0]   s0_wdata;
    logic [DW-1:0]   s1_wdata;
    logic [DW/8-1:0] s0_wstrb;
    logic [DW/8-1:0] s1_wstrb;
    logic            s0_rsp_valid;
    logic            s1_rsp_valid;
    logic [DW-1:0]   s_rdata;
    logic            m_valid;
    logic            m_ready;
    logic [AW-1:0]   m_addr;
    logic            m_we;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_wstrb;
    logic            m_rsp_valid;
    logic [DW-1:0]   m_rdata;

    modport slave (
        input  s0_valid, s1_valid, s0_addr, s1_addr, s0_we, s1_we,
               s0_wdata, s1_wdata, s0_wstrb, s1_wstrb,
               m_ready, m_rsp_valid, m_rdata,
        output s0_ready, s1_ready, s0_rsp_valid, s1_rsp_valid, s_rdata,
               m_valid, m_addr, m_we, m_wdata, m_wstrb
    );

    modport master (
        output s0_valid, s1_valid, s0_addr, s1_addr, s0_we, s1_we,
               s0_wdata, s1_wdata, s0_wstrb, s1_wstrb,
               m_ready, m_rsp_valid, m_rdata,
        input  s0_ready, s1_ready, s0_rsp_valid, s1_rsp_valid, s_rdata,
               m_valid, m_addr, m_we, m_wdata, m_wstrb
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (0) and load/store (1), one transaction in flight; handshake to response is 3 cycles at zero wait.
// Backpressure: requesters see ready only while idle; the request is held on the memory side until m_ready, response wait is unbounded.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_last;
    logic            r_owner;
    logic            r_m_valid;
    logic [AW-1:0]   r_m_addr;
    logic            r_m_we;
    logic [DW-1:0]   r_m_wdata;
    logic [DW/8-1:0] r_m_wstrb;
    logic            r_s0_rsp_valid;
    logic            r_s1_rsp_valid;
    logic [DW-1:0]   r_s_rdata;

    logic            w_any;
    logic            w_grant;
    logic            w_take;

    // w_grant is the winning port index; it only matters while w_any is set.
    always_comb begin
        w_any   = bus.s0_valid | bus.s1_valid;
        w_grant = bus.s1_valid;
        if (bus.s0_valid && bus.s1_valid) begin
            w_grant = FIXED_PRIO ? 1'b1 : ~r_last;
        end
    end

    assign w_take       = (r_state == IDLE) & w_any;
    assign bus.s0_ready = w_take & ~w_grant;
    assign bus.s1_ready = w_take & w_grant;

    assign bus.m_valid      = r_m_valid;
    assign bus.m_addr       = r_m_addr;
    assign bus.m_we         = r_m_we;
    assign bus.m_wdata      = r_m_wdata;
    assign bus.m_wstrb      = r_m_wstrb;
    assign bus.s0_rsp_valid = r_s0_rsp_valid;
    assign bus.s1_rsp_valid = r_s1_rsp_valid;
    assign bus.s_rdata      = r_s_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_last         <= 1'b1;
            r_owner        <= 1'b0;
            r_m_valid      <= 1'b0;
            r_m_addr       <= '0;
            r_m_we         <= 1'b0;
            r_m_wdata      <= '0;
            r_m_wstrb      <= '0;
            r_s0_rsp_valid <= 1'b0;
            r_s1_rsp_valid <= 1'b0;
            r_s_rdata      <= '0;
        end else begin
            r_s0_rsp_valid <= 1'b0;
            r_s1_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_m_addr  <= w_grant ? bus.s1_addr  : bus.s0_addr;
                        r_m_we    <= w_grant ? bus.s1_we    : bus.s0_we;
                        r_m_wdata <= w_grant ? bus.s1_wdata : bus.s0_wdata;
                        r_m_wstrb <= w_grant ? bus.s1_wstrb : bus.s0_wstrb;
                        r_owner   <= w_grant;
                        r_last    <= w_grant;
                        r_m_valid <= 1'b1;
                        r_state   <= REQ;
                    end
                end
                REQ: begin
                    if (bus.m_ready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= RESP;
                    end
                end
                RESP: begin
                    // Write acks also load s_rdata; owners ignore it for writes.
                    if (bus.m_rsp_valid) begin
                        r_s_rdata      <= bus.m_rdata;
                        r_s0_rsp_valid <= ~r_owner;
                        r_s1_rsp_valid <= r_owner;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
